// File: rtl/card_dealer_pkg.sv
// Shared types and constants for the card dealer and its LFSR.
package card_dealer_pkg;

  typedef logic [3:0] card;

  localparam int          DECK_SIZE    = 52;
  localparam card         ACE_VALUE    = 4'd1;
  localparam card         FACE_VALUE   = 4'd10;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_MASK    = 16'hB400;

  typedef enum logic {
    ST_SHUFFLE = 1'b0,
    ST_READY   = 1'b1
  } state_e;

  // Blackjack value of slot k in a freshly collected deck: ranks A..K, faces count 10.
  function automatic card canon_value(input int k);
    int v;
    v = (k % 13) + 1;
    if (v > int'(FACE_VALUE)) v = int'(FACE_VALUE);
    return card'(v);
  endfunction

endpackage

// File: rtl/card_dealer_lfsr16.sv
// 16-bit Galois LFSR, free-running; reseeded while reset is held.
module lfsr16 #(
  parameter logic [15:0] DEFAULT_SEED = card_dealer_pkg::DEFAULT_SEED
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [15:0] i_seed,
  output logic [15:0] o_value
);

  logic [15:0] lfsr_q, lfsr_d;

  // Shift right, fold the mask in when the bit falling out is set.
  always_comb begin
    lfsr_d = lfsr_q >> 1;
    if (lfsr_q[0]) lfsr_d = (lfsr_q >> 1) ^ card_dealer_pkg::LFSR_MASK;
  end

  // A zero seed would lock the register up, so fall back to the default.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) lfsr_q <= (i_seed == 16'd0) ? DEFAULT_SEED : i_seed;
    else            lfsr_q <= lfsr_d;
  end

  assign o_value = lfsr_q;

endmodule

// File: rtl/card_dealer.sv
// 52-card blackjack deck with in-place Fisher-Yates shuffle and single-card dealing.
module card_dealer
  import card_dealer_pkg::*;
#(
  parameter bit          SHUFFLE_EN   = 1'b1,
  parameter logic [15:0] DEFAULT_SEED = card_dealer_pkg::DEFAULT_SEED
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [15:0] i_seed,
  input  logic        i_dealReq,
  input  logic        i_shuffle,
  output logic        o_addNewCard,
  output card         o_newCard,
  output logic [5:0]  o_cardsRemaining,
  output logic        o_deckEmpty,
  output logic        o_busy
);

  localparam state_e     RESET_STATE = SHUFFLE_EN ? ST_SHUFFLE : ST_READY;
  localparam logic [5:0] LAST_IDX    = 6'(DECK_SIZE - 1);

  state_e      state_q, state_d;
  logic [5:0]  idx_q, idx_d;
  logic [5:0]  ptr_q, ptr_d;
  card         deck_q [DECK_SIZE];
  logic        add_q;
  card         newCard_q;
  logic        swap_go, deal_go;
  logic [15:0] lfsr;
  logic [5:0]  r;
  logic        lfsr_unused;

  lfsr16 #(.DEFAULT_SEED(DEFAULT_SEED)) u_lfsr (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .i_seed   (i_seed),
    .o_value  (lfsr)
  );

  // Only the low six bits pick the swap partner; out-of-range picks are rejected.
  assign r           = lfsr[5:0];
  assign lfsr_unused = ^lfsr[15:6];

  // Next state: one swap per accepted sample while shuffling, otherwise shuffle/deal.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    swap_go = 1'b0;
    deal_go = 1'b0;
    case (state_q)
      ST_SHUFFLE: begin
        if (r <= idx_q) begin
          swap_go = 1'b1;
          if (idx_q == 6'd1) state_d = ST_READY;
          else               idx_d   = idx_q - 6'd1;
        end
      end
      ST_READY: begin
        // Shuffle beats a simultaneous deal request.
        if (i_shuffle) begin
          ptr_d = 6'd0;
          if (SHUFFLE_EN) begin
            state_d = ST_SHUFFLE;
            idx_d   = LAST_IDX;
          end
        end else if (i_dealReq && (int'(ptr_q) < DECK_SIZE)) begin
          deal_go = 1'b1;
          ptr_d   = ptr_q + 6'd1;
        end
      end
      default: state_d = ST_READY;
    endcase
  end

  // Control registers.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q <= RESET_STATE;
      idx_q   <= LAST_IDX;
      ptr_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
    end
  end

  // Deck storage: canonical load on reset, swap of slots idx and r when accepted.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      for (int k = 0; k < DECK_SIZE; k++) deck_q[k] <= canon_value(k);
    end else if (swap_go) begin
      deck_q[idx_q] <= deck_q[r];
      deck_q[r]     <= deck_q[idx_q];
    end
  end

  // Deal strobe and card; the card value holds until the next deal.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      add_q     <= 1'b0;
      newCard_q <= '0;
    end else begin
      add_q <= deal_go;
      if (deal_go) newCard_q <= deck_q[ptr_q];
    end
  end

  assign o_addNewCard     = add_q;
  assign o_newCard        = newCard_q;
  assign o_cardsRemaining = 6'(DECK_SIZE) - ptr_q;
  assign o_deckEmpty      = (int'(ptr_q) == DECK_SIZE);
  assign o_busy           = (state_q == ST_SHUFFLE);

endmodule
